// File: rtl/note_pkg.sv
// Shared types and codes for the note framer / emitter pair.
package note_pkg;

   localparam int unsigned NOTE_W   = 8;
   localparam int unsigned DUR_W    = 4;
   localparam int unsigned LETTER_W = 4;

   // One-hot duration codes presented to the score renderer.
   localparam logic [DUR_W-1:0] DUR_NONE    = 4'b0000;
   localparam logic [DUR_W-1:0] DUR_EIGHTH  = 4'b0001;
   localparam logic [DUR_W-1:0] DUR_QUARTER = 4'b0010;
   localparam logic [DUR_W-1:0] DUR_HALF    = 4'b0100;
   localparam logic [DUR_W-1:0] DUR_WHOLE   = 4'b1000;

   localparam logic [LETTER_W-1:0] REST_LETTER = 4'h0;

   typedef enum logic {
      R_IDLE,
      R_RUN
   } run_state_e;

   typedef enum logic [1:0] {
      E_IDLE,
      E_HIGH,
      E_LOW
   } emit_state_e;

   // Note + duration pair handed from the run tracker to the emitter.
   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [DUR_W-1:0]  dur;
   } emit_req_t;

   function automatic logic is_rest(input logic [LETTER_W-1:0] letter);
      return letter == REST_LETTER;
   endfunction

endpackage

// File: rtl/note_emitter.sv
// Stretches each emission into a PULSE_CYCLES-wide new_note pulse with an
// equally long quiet gap, buffering one request that arrives meanwhile.
module note_emitter
   import note_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [NOTE_W-1:0] req_note,
   input  logic [DUR_W-1:0]  req_dur,
   output logic [NOTE_W-1:0] note,
   output logic [DUR_W-1:0]  duration,
   output logic              new_note,
   output logic              overflow
);

   localparam int unsigned   PC_W    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_CYCLES - 1);

   emit_state_e       state_q, state_d;
   logic [PC_W-1:0]   cnt_q, cnt_d;
   emit_req_t         pend_q, pend_d;
   logic              pend_v_q, pend_v_d;
   logic [NOTE_W-1:0] note_d;
   logic [DUR_W-1:0]  dur_d;
   logic              nn_d;
   logic              ovf_d;

   emit_req_t         incoming_c;
   emit_req_t         load_sel_c;
   logic              load_c;
   logic              buffer_c;

   // State, phase counter, pending slot and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= E_IDLE;
         cnt_q    <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         note     <= '0;
         duration <= '0;
         new_note <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         note     <= note_d;
         duration <= dur_d;
         new_note <= nn_d;
         overflow <= ovf_d;
      end
   end

   // Next state: pulse high phase, enforced low gap, pending handoff.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      pend_v_d   = pend_v_q;
      note_d     = note;
      dur_d      = duration;
      nn_d       = new_note;
      ovf_d      = overflow;
      incoming_c = '{note: req_note, dur: req_dur};
      load_sel_c = incoming_c;
      load_c     = 1'b0;
      buffer_c   = 1'b0;

      case (state_q)
         E_IDLE: begin
            load_c = req_valid;
         end
         E_HIGH: begin
            buffer_c = req_valid;
            if (cnt_q == PC_LAST) begin
               state_d = E_LOW;
               cnt_d   = '0;
               nn_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + PC_W'(1);
            end
         end
         E_LOW: begin
            if (cnt_q == PC_LAST) begin
               if (pend_v_q) begin
                  // Oldest first; a same-cycle request refills the slot.
                  load_c     = 1'b1;
                  load_sel_c = pend_q;
                  pend_v_d   = 1'b0;
                  buffer_c   = req_valid;
               end else if (req_valid) begin
                  load_c = 1'b1;
               end else begin
                  state_d = E_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d    = cnt_q + PC_W'(1);
               buffer_c = req_valid;
            end
         end
         default: begin
            state_d = E_IDLE;
            cnt_d   = '0;
            nn_d    = 1'b0;
         end
      endcase

      if (load_c) begin
         note_d  = load_sel_c.note;
         dur_d   = load_sel_c.dur;
         nn_d    = 1'b1;
         state_d = E_HIGH;
         cnt_d   = '0;
      end

      if (buffer_c) begin
         if (pend_v_d) begin
            ovf_d = 1'b1;
         end else begin
            pend_d   = incoming_c;
            pend_v_d = 1'b1;
         end
      end
   end

endmodule

// File: rtl/note_framer.sv
// Groups consecutive identical FFT-frame pitch codes into runs, classifies
// each closed run into a note duration and hands it to the pulse emitter.
module note_framer
   import note_pkg::*;
#(
   parameter int unsigned MIN_FRAMES   = 2,
   parameter int unsigned QUARTER_MIN  = 4,
   parameter int unsigned HALF_MIN     = 8,
   parameter int unsigned WHOLE_MIN    = 16,
   parameter int unsigned WHOLE_MAX    = 22,
   parameter int unsigned PULSE_CYCLES = 16,
   parameter int unsigned CNT_W        = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_valid,
   input  logic [7:0]  frame_note,
   output logic [7:0]  note,
   output logic [3:0]  duration,
   output logic        new_note,
   output logic        overflow
);

   run_state_e        state_q, state_d;
   logic [NOTE_W-1:0] cur_q, cur_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [CNT_W-1:0]  cnt_inc_c;
   logic [DUR_W-1:0]  close_dur_c;
   logic              req_valid_c;
   logic [NOTE_W-1:0] req_note_c;
   logic [DUR_W-1:0]  req_dur_c;

   // Run tracker state: current pitch and how many frames it has lasted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= R_IDLE;
         cur_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
      end
   end

   // Duration class of the run as it stands; DUR_NONE marks a glitch.
   always_comb begin
      if (cnt_q < CNT_W'(MIN_FRAMES)) begin
         close_dur_c = DUR_NONE;
      end else if (cnt_q < CNT_W'(QUARTER_MIN)) begin
         close_dur_c = DUR_EIGHTH;
      end else if (cnt_q < CNT_W'(HALF_MIN)) begin
         close_dur_c = DUR_QUARTER;
      end else if (cnt_q < CNT_W'(WHOLE_MIN)) begin
         close_dur_c = DUR_HALF;
      end else begin
         close_dur_c = DUR_WHOLE;
      end
   end

   assign cnt_inc_c = cnt_q + CNT_W'(1);

   // Per-frame run bookkeeping and emission requests.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      cnt_d       = cnt_q;
      req_valid_c = 1'b0;
      req_note_c  = cur_q;
      req_dur_c   = DUR_NONE;

      if (frame_valid) begin
         case (state_q)
            R_IDLE: begin
               if (!is_rest(frame_note[7:4])) begin
                  cur_d   = frame_note;
                  cnt_d   = CNT_W'(1);
                  state_d = R_RUN;
               end
            end
            R_RUN: begin
               if (frame_note == cur_q) begin
                  if (cnt_inc_c == CNT_W'(WHOLE_MAX)) begin
                     // Long hold: emit a whole note now, keep the run tied.
                     req_valid_c = 1'b1;
                     req_dur_c   = DUR_WHOLE;
                     cnt_d       = '0;
                  end else begin
                     cnt_d = cnt_inc_c;
                  end
               end else begin
                  req_valid_c = (close_dur_c != DUR_NONE);
                  req_dur_c   = close_dur_c;
                  if (is_rest(frame_note[7:4])) begin
                     state_d = R_IDLE;
                     cnt_d   = '0;
                  end else begin
                     cur_d = frame_note;
                     cnt_d = CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = R_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   note_emitter #(
      .PULSE_CYCLES (PULSE_CYCLES)
   ) u_emitter (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid_c),
      .req_note  (req_note_c),
      .req_dur   (req_dur_c),
      .note      (note),
      .duration  (duration),
      .new_note  (new_note),
      .overflow  (overflow)
   );

endmodule

// File: tb/tb_note_framer.sv
// Directed bench for note_framer: run classification, pulse shaping,
// pending/overflow behaviour and asynchronous reset.
module tb_note_framer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_valid = 1'b0;
   logic [7:0] frame_note = 8'h00;
   logic [7:0] note;
   logic [3:0] duration;
   logic       new_note;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   logic [7:0] em_note[$];
   logic [3:0] em_dur[$];
   int         em_cyc[$];
   int         len_q[$];
   int         unstable = 0;
   int         cyc = 0;
   int         hi_len = 0;
   logic       nn_prev = 1'b0;
   logic [7:0] note_hold = 8'h00;
   logic [3:0] dur_hold = 4'h0;

   always #5 clk = ~clk;

   note_framer dut (
      .clk         (clk),
      .reset       (reset),
      .frame_valid (frame_valid),
      .frame_note  (frame_note),
      .note        (note),
      .duration    (duration),
      .new_note    (new_note),
      .overflow    (overflow)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Record every pulse: rise time, payload, width and payload stability.
   always @(negedge clk) begin
      if (new_note && !nn_prev) begin
         em_note.push_back(note);
         em_dur.push_back(duration);
         em_cyc.push_back(cyc);
         hi_len = 0;
      end
      if (new_note) hi_len = hi_len + 1;
      if (!new_note && nn_prev) len_q.push_back(hi_len);
      if (new_note && nn_prev && (note != note_hold || duration != dur_hold))
         unstable = unstable + 1;
      nn_prev   = new_note;
      note_hold = note;
      dur_hold  = duration;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle frame strobe; returns on the negedge after the capturing edge.
   task automatic strobe(input logic [7:0] n);
      @(negedge clk);
      frame_note  = n;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
   endtask

   task automatic clear_log();
      em_note.delete();
      em_dur.delete();
      em_cyc.delete();
      len_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      frame_valid = 1'b0;
      reset = 1'b0;
      idle(3);
      clear_log();
      reset = 1'b1;
      idle(2);
   endtask

   initial begin
      // Reset values
      idle(3);
      chk("rst_note", 32'(note), 32'h00);
      chk("rst_dur", 32'(duration), 32'h0);
      chk("rst_nn", 32'(new_note), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      clear_log();
      reset = 1'b1;
      idle(2);

      // Three frames then rest: eighth note, one cycle latency, 16-cycle pulse
      for (int i = 0; i < 3; i++) begin
         strobe(8'h52);
         idle(3);
      end
      chk("t1_pre_nn", 32'(new_note), 32'h0);
      strobe(8'h00);
      chk("t1_nn", 32'(new_note), 32'h1);
      chk("t1_note", 32'(note), 32'h52);
      chk("t1_dur", 32'(duration), 32'h1);
      idle(40);
      chk("t1_count", 32'(em_note.size()), 32'd1);
      if (len_q.size() >= 1) chk("t1_width", 32'(len_q[0]), 32'd16);

      // Single-frame glitch is discarded
      do_reset();
      strobe(8'h00);
      idle(3);
      strobe(8'h31);
      idle(3);
      strobe(8'h00);
      idle(50);
      chk("t2_count", 32'(em_note.size()), 32'd0);
      chk("t2_note", 32'(note), 32'h00);
      chk("t2_dur", 32'(duration), 32'h0);

      // 5 x 0x52 then 10 x 0x62 then rest, frames 200 cycles apart
      do_reset();
      for (int i = 0; i < 5; i++) begin
         strobe(8'h52);
         idle(198);
      end
      strobe(8'h62);
      chk("t3_first_nn", 32'(new_note), 32'h1);
      chk("t3_first_note", 32'(note), 32'h52);
      chk("t3_first_dur", 32'(duration), 32'h2);
      idle(198);
      for (int i = 0; i < 9; i++) begin
         strobe(8'h62);
         idle(198);
      end
      strobe(8'h00);
      chk("t3_second_nn", 32'(new_note), 32'h1);
      idle(50);
      chk("t3_count", 32'(em_note.size()), 32'd2);
      if (em_note.size() >= 2) begin
         chk("t3_note1", 32'(em_note[1]), 32'h62);
         chk("t3_dur1", 32'(em_dur[1]), 32'h4);
      end

      // 22-frame hold forces a whole note; tied remainder becomes eighth
      do_reset();
      for (int i = 0; i < 21; i++) begin
         strobe(8'h44);
         idle(2);
      end
      chk("t4_pre_nn", 32'(new_note), 32'h0);
      strobe(8'h44);
      chk("t4_whole_nn", 32'(new_note), 32'h1);
      chk("t4_whole_note", 32'(note), 32'h44);
      chk("t4_whole_dur", 32'(duration), 32'h8);
      idle(2);
      strobe(8'h44);
      idle(2);
      strobe(8'h44);
      idle(2);
      strobe(8'h00);
      idle(60);
      chk("t4_count", 32'(em_note.size()), 32'd2);
      if (em_note.size() >= 2) begin
         chk("t4_tail_note", 32'(em_note[1]), 32'h44);
         chk("t4_tail_dur", 32'(em_dur[1]), 32'h1);
         chk("t4_gap", 32'(em_cyc[1] - em_cyc[0]), 32'd32);
      end
      chk("t4_ovf", 32'(overflow), 32'h0);

      // Back-to-back short runs: one pending, third dropped
      do_reset();
      strobe(8'h52);
      strobe(8'h52);
      strobe(8'h62);
      strobe(8'h62);
      strobe(8'h72);
      strobe(8'h72);
      strobe(8'h00);
      chk("t5_ovf_early", 32'(overflow), 32'h1);
      idle(80);
      chk("t5_count", 32'(em_note.size()), 32'd2);
      if (em_note.size() >= 2) begin
         chk("t5_note0", 32'(em_note[0]), 32'h52);
         chk("t5_note1", 32'(em_note[1]), 32'h62);
         chk("t5_dur1", 32'(em_dur[1]), 32'h1);
         chk("t5_gap", 32'(em_cyc[1] - em_cyc[0]), 32'd32);
      end
      if (len_q.size() >= 2) chk("t5_width1", 32'(len_q[1]), 32'd16);
      chk("t5_ovf", 32'(overflow), 32'h1);

      // Asynchronous reset during the high phase with the pending slot full
      do_reset();
      strobe(8'h52);
      strobe(8'h52);
      strobe(8'h62);
      strobe(8'h62);
      strobe(8'h72);
      idle(3);
      chk("t6_pre_nn", 32'(new_note), 32'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_async_nn", 32'(new_note), 32'h0);
      chk("t6_async_note", 32'(note), 32'h00);
      idle(2);
      clear_log();
      reset = 1'b1;
      idle(100);
      chk("t6_count", 32'(em_note.size()), 32'd0);
      chk("t6_ovf", 32'(overflow), 32'h0);
      chk("t6_nn", 32'(new_note), 32'h0);

      chk("payload_stable", 32'(unstable), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/note_framer.md
Name: note_framer

Overview:
Producer end of the note/duration/new_note interface that the VGA score renderer consumes. Accepts one pitch code per FFT frame (5 kHz, 512 samples, 0.1024 s per frame) and counts consecutive identical frames. When a run closes, it classifies the run length into a duration code and presents note + duration with a stretched new_note pulse. The pulse is long enough for the VGA-domain 3-flop synchronizer to capture.

Parameters:
MIN_FRAMES, 2, runs shorter than this are glitches and are discarded
QUARTER_MIN, 4, first run length classified as quarter
HALF_MIN, 8, first run length classified as half
WHOLE_MIN, 16, first run length classified as whole
WHOLE_MAX, 22, run length that forces an immediate whole-note emission
PULSE_CYCLES, 16, new_note high time, and also the minimum low time between pulses
CNT_W, 5, run counter width; must hold WHOLE_MAX

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
frame_valid  in  1  one-cycle strobe, one per FFT frame
frame_note  in  8  letter(4b)_octave(3b)_accidental(1b); letter==0 means rest
note  out  8  emitted note code; stable while new_note is high and until the next emission
duration  out  4  one-hot: 0001 eighth, 0010 quarter, 0100 half, 1000 whole
new_note  out  1  high for PULSE_CYCLES cycles per emission
overflow  out  1  sticky; set when an emission is dropped

Behaviour:
- Reset (async, reset==0): note=0, duration=0, new_note=0, overflow=0; run FSM to IDLE; run_cnt=0; emitter to E_IDLE; pending buffer empty. Reset mid-pulse drops new_note immediately.
- Run FSM, evaluated only on cycles with frame_valid=1:
  - IDLE, rest frame: stay IDLE.
  - IDLE, non-rest frame: cur_note=frame_note, run_cnt=1, go to RUN.
  - RUN, frame_note==cur_note (all 8 bits):
    - run_cnt+1==WHOLE_MAX: request emit(cur_note, 1000), run_cnt=0, stay in RUN (tied note continues).
    - otherwise: run_cnt+1.
  - RUN, different non-rest frame: close the run, then cur_note=frame_note, run_cnt=1.
  - RUN, rest frame: close the run, go to IDLE.
- Close classification on run_cnt:
  - <MIN_FRAMES: discard, no request.
  - <QUARTER_MIN: 0001.
  - <HALF_MIN: 0010.
  - <WHOLE_MIN: 0100.
  - otherwise: 1000.
- Emitter FSM, states E_IDLE, E_HIGH, E_LOW:
  - A request in E_IDLE loads note and duration on the same edge. new_note=1 from the next cycle (latency 1 cycle from the closing frame_valid). Go to E_HIGH.
  - E_HIGH lasts exactly PULSE_CYCLES cycles, then E_LOW.
  - E_LOW holds new_note=0 for PULSE_CYCLES cycles. If pending is valid, load it and go to E_HIGH; otherwise go to E_IDLE.
  - A request while in E_HIGH or E_LOW goes into the one-deep pending buffer. If pending is already full, the request is dropped and overflow=1 (cleared only by reset).
  - note and duration change only on the load edge, never while new_note is high.
- A run close and a WHOLE_MAX emission cannot both occur on one frame. A pending load and a new request on the same cycle: pending loads, and the new request fills the now-empty buffer.

Decomposition:
- Package note_pkg holds:
  - duration code constants DUR_EIGHTH, DUR_QUARTER, DUR_HALF, DUR_WHOLE;
  - REST_LETTER=4'h0;
  - enums for the run FSM and the emitter FSM.
- Sub-module note_emitter implements the emitter FSM, the pending buffer, the PULSE_CYCLES counter and overflow. note_framer holds the run FSM and the classifier.

Test Plan:
- 3 frames of 0x52, then a rest frame -> cycle after the rest strobe: note=0x52, duration=0001, new_note high exactly 16 cycles.
- rest, a single frame of 0x31, rest -> new_note never rises; note/duration stay 0.
- 5 frames of 0x52, 10 frames of 0x62, rest (frames 200 cycles apart) -> emission 0x52/0010, then 0x62/0100.
- 22 consecutive frames of 0x44 -> emission 0x44/1000 on the 22nd frame with no rest; a 23rd–24th frame of 0x44 followed by rest -> 0x44/0001.
- Three 2-frame runs (0x52, 0x62, 0x72) closed with frame_valid every 2 cycles -> 0x52 emitted; 0x62 emitted after 32 cycles (16 high + 16 low); 0x72 dropped; overflow=1.
- reset pulled low during E_HIGH with pending full -> new_note=0 immediately; after release there are no further emissions and overflow=0.
